// File: rtl/div_recompose_if.sv
// rtl/div_recompose_if.sv - start/done handshake and operand/result bundle for div_recompose
interface div_recompose_if #(parameter int N = 4);
    logic           start;
    logic [N-1:0]   Q;
    logic [N-1:0]   B;
    logic [N-1:0]   R;
    logic [N-1:0]   A_ref;
    logic           busy;
    logic           done;
    logic [2*N-1:0] P;
    logic           match;
    logic           div_err;
    logic           rem_err;

    modport master (
        output start, Q, B, R, A_ref,
        input  busy, done, P, match, div_err, rem_err
    );

    modport slave (
        input  start, Q, B, R, A_ref,
        output busy, done, P, match, div_err, rem_err
    );
endinterface

// File: rtl/div_recompose.sv
// rtl/div_recompose.sv - shift-add rebuild of P=Q*B+R checked against A_ref; RECOMP_SSD_EN adds 3-digit 7-seg display of P
module div_recompose #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef RECOMP_SSD_EN
    output logic [6:0] ssdPC,
    output logic [6:0] ssdPD,
    output logic [6:0] ssdPU,
`endif
    div_recompose_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]     state_q, state_d;
    logic [2*N-1:0] acc_q, acc_d, mcand_q, mcand_d, p_q, p_d, acc_sum;
    logic [N-1:0]   mplier_q, mplier_d, aref_q, aref_d;
    logic [CW-1:0]  count_q, count_d;
    logic           match_q, match_d, div_err_q, div_err_d, rem_err_q, rem_err_d;

    // P and match are registered on the edge entering DONE so they are valid alongside done
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        aref_d    = aref_q;
        count_d   = count_q;
        p_d       = p_q;
        match_d   = match_q;
        div_err_d = div_err_q;
        rem_err_d = rem_err_q;
        acc_sum   = mplier_q[0] ? acc_q + mcand_q : acc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d     = {{N{1'b0}}, bus.R};
                    mcand_d   = {{N{1'b0}}, bus.B};
                    mplier_d  = bus.Q;
                    aref_d    = bus.A_ref;
                    count_d   = '0;
                    div_err_d = (bus.B == '0);
                    rem_err_d = (bus.B != '0) && (bus.R >= bus.B);
                    match_d   = 1'b0;
                    if (bus.B == '0) begin
                        state_d = S_DONE;
                        p_d     = '0;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d = S_DONE;
                    p_d     = acc_sum;
                    match_d = (acc_sum == {{N{1'b0}}, aref_q});
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            aref_q    <= '0;
            count_q   <= '0;
            p_q       <= '0;
            match_q   <= 1'b0;
            div_err_q <= 1'b0;
            rem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            aref_q    <= aref_d;
            count_q   <= count_d;
            p_q       <= p_d;
            match_q   <= match_d;
            div_err_q <= div_err_d;
            rem_err_q <= rem_err_d;
        end
    end

    assign bus.busy    = (state_q == S_BUSY);
    assign bus.done    = (state_q == S_DONE);
    assign bus.P       = p_q;
    assign bus.match   = match_q;
    assign bus.div_err = div_err_q;
    assign bus.rem_err = rem_err_q;

`ifdef RECOMP_SSD_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [3:0] hund, tens, units;
    logic [6:0] ssd_c_q, ssd_c_d, ssd_d_q, ssd_d_d, ssd_u_q, ssd_u_d;

    // Decimal split works from the registered P, so the display trails P by one cycle
    always_comb begin
        hund    = 4'(p_q / 100);
        tens    = 4'((p_q / 10) % 10);
        units   = 4'(p_q % 10);
        ssd_c_d = seg7(hund);
        ssd_d_d = seg7(tens);
        ssd_u_d = seg7(units);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ssd_c_q <= 7'b1000000;
            ssd_d_q <= 7'b1000000;
            ssd_u_q <= 7'b1000000;
        end else begin
            ssd_c_q <= ssd_c_d;
            ssd_d_q <= ssd_d_d;
            ssd_u_q <= ssd_u_d;
        end
    end

    assign ssdPC = ssd_c_q;
    assign ssdPD = ssd_d_q;
    assign ssdPU = ssd_u_q;
`endif
endmodule

// File: tb/tb_div_recompose.sv
// tb/tb_div_recompose.sv - scoreboard bench for div_recompose (display checks under RECOMP_SSD_EN)
module tb_div_recompose;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_recompose_if #(.N(N)) bus ();
`ifdef RECOMP_SSD_EN
    logic [6:0] ssdPC, ssdPD, ssdPU;
`endif

    div_recompose #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef RECOMP_SSD_EN
        .ssdPC (ssdPC),
        .ssdPD (ssdPD),
        .ssdPU (ssdPU),
`endif
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] p;
        logic       m;
        logic       de;
        logic       re;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic apply(input logic [3:0] q, input logic [3:0] b, input logic [3:0] r,
                         input logic [3:0] a, input bit hold);
        exp_t e;
        logic [7:0] p;
        p    = {4'b0, q} * {4'b0, b} + {4'b0, r};
        e.p  = (b == 0) ? 8'd0 : p;
        e.m  = (b != 0) && (p == {4'b0, a});
        e.de = (b == 0);
        e.re = (b != 0) && (r >= b);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.Q = q; bus.B = b; bus.R = r; bus.A_ref = a; bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            bus.start = 1'b0;
            bus.Q = 4'($urandom); bus.B = 4'($urandom); bus.R = 4'($urandom); bus.A_ref = 4'($urandom);
        end
    endtask

    task automatic wait_done(output int busy_cyc, output int done_cyc, output bit timeout);
        busy_cyc = 0; done_cyc = 0; timeout = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cyc = i; timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.P, bus.match, bus.div_err, bus.rem_err} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outs: got busy=%b done=%b P=%0d match=%b de=%b re=%b want all 0",
                     bus.busy, bus.done, bus.P, bus.match, bus.div_err, bus.rem_err);
        end
`ifdef RECOMP_SSD_EN
        vectors++;
        if ({ssdPC, ssdPD, ssdPU} !== {3{7'b1000000}}) begin
            miscompares++;
            $display("FAIL reset_ssd: got %b %b %b want 1000000 x3", ssdPC, ssdPD, ssdPU);
        end
`endif
    endtask

    task automatic test_normal;
        int bc, dc; bit to; exp_t e;
        apply(4'd3, 4'd4, 4'd1, 4'd13, 1'b0);
        wait_done(bc, dc, to);
        vectors++; if (to) begin miscompares++; $display("FAIL norm_timeout: no done within 20 cycles"); end
        vectors++; if (bc != 4) begin miscompares++; $display("FAIL norm_busy: got %0d cycles want 4", bc); end
        vectors++; if (dc != 5) begin miscompares++; $display("FAIL norm_lat: got done at %0d want 5", dc); end
        e = sb.pop_front();
        vectors++; if (bus.P !== e.p) begin miscompares++; $display("FAIL norm_p: got %0d want %0d", bus.P, e.p); end
        vectors++; if ({bus.match, bus.div_err, bus.rem_err} !== {e.m, e.de, e.re}) begin
            miscompares++;
            $display("FAIL norm_flags: got m/de/re=%b%b%b want %b%b%b", bus.match, bus.div_err, bus.rem_err, e.m, e.de, e.re);
        end
        @(negedge clk);
        vectors++; if (bus.done !== 1'b0 || bus.P !== 8'd13) begin
            miscompares++; $display("FAIL norm_hold: got done=%b P=%0d want done=0 P=13", bus.done, bus.P);
        end
`ifdef RECOMP_SSD_EN
        vectors++;
        if ({ssdPC, ssdPD, ssdPU} !== {seg_ref(0), seg_ref(1), seg_ref(3)}) begin
            miscompares++; $display("FAIL norm_ssd: got %b %b %b want digits 0 1 3", ssdPC, ssdPD, ssdPU);
        end
`endif
    endtask

    task automatic test_max;
        int bc, dc; bit to; exp_t e;
        apply(4'd15, 4'd15, 4'd15, 4'd0, 1'b0);
        vectors++; if (bus.rem_err !== 1'b1 || bus.P !== 8'd13) begin
            miscompares++; $display("FAIL max_accept: got re=%b P=%0d want re=1 P=13 held", bus.rem_err, bus.P);
        end
        wait_done(bc, dc, to);
        vectors++; if (to || dc != 5) begin miscompares++; $display("FAIL max_lat: got done at %0d (timeout=%b) want 5", dc, to); end
        e = sb.pop_front();
        vectors++; if (bus.P !== e.p) begin miscompares++; $display("FAIL max_p: got %0d want %0d", bus.P, e.p); end
        vectors++; if ({bus.match, bus.div_err, bus.rem_err} !== {e.m, e.de, e.re}) begin
            miscompares++;
            $display("FAIL max_flags: got m/de/re=%b%b%b want %b%b%b", bus.match, bus.div_err, bus.rem_err, e.m, e.de, e.re);
        end
        @(negedge clk);
`ifdef RECOMP_SSD_EN
        vectors++;
        if ({ssdPC, ssdPD, ssdPU} !== {seg_ref(2), seg_ref(4), seg_ref(0)}) begin
            miscompares++; $display("FAIL max_ssd: got %b %b %b want digits 2 4 0", ssdPC, ssdPD, ssdPU);
        end
`endif
    endtask

    task automatic test_div_zero;
        int bc, dc; bit to; exp_t e;
        apply(4'd7, 4'd0, 4'd2, 4'd2, 1'b0);
        wait_done(bc, dc, to);
        vectors++; if (to || dc != 1) begin miscompares++; $display("FAIL dz_lat: got done at %0d (timeout=%b) want 1", dc, to); end
        vectors++; if (bc != 0) begin miscompares++; $display("FAIL dz_busy: got %0d busy cycles want 0", bc); end
        e = sb.pop_front();
        vectors++; if (bus.P !== e.p) begin miscompares++; $display("FAIL dz_p: got %0d want %0d", bus.P, e.p); end
        vectors++; if ({bus.match, bus.div_err, bus.rem_err} !== {e.m, e.de, e.re}) begin
            miscompares++;
            $display("FAIL dz_flags: got m/de/re=%b%b%b want %b%b%b", bus.match, bus.div_err, bus.rem_err, e.m, e.de, e.re);
        end
    endtask

    task automatic test_ignore_start;
        int dones = 0; exp_t e; logic [7:0] p_at_done = 8'hff;
        apply(4'd2, 4'd5, 4'd0, 4'd10, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.done) begin dones++; p_at_done = bus.P; end
            bus.start = (i == 2 || i == 5);
            bus.Q = 4'd9; bus.B = 4'd0; bus.R = 4'd3;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        vectors++; if (dones != 1) begin miscompares++; $display("FAIL ign_dones: got %0d done pulses want 1", dones); end
        vectors++; if (p_at_done !== e.p) begin miscompares++; $display("FAIL ign_p: got %0d want %0d", p_at_done, e.p); end
    endtask

    task automatic test_back_to_back;
        int bc, dc; bit to; exp_t e;
        apply(4'd1, 4'd3, 4'd2, 4'd5, 1'b1);
        sb.push_back(sb[$]);
        wait_done(bc, dc, to);
        vectors++; if (to || dc != 5) begin miscompares++; $display("FAIL b2b_lat1: got done at %0d (timeout=%b) want 5", dc, to); end
        e = sb.pop_front();
        vectors++; if (bus.P !== e.p || bus.match !== e.m) begin
            miscompares++; $display("FAIL b2b_p1: got P=%0d m=%b want P=%0d m=%b", bus.P, bus.match, e.p, e.m);
        end
        @(negedge clk);
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        @(negedge clk);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_reaccept: got busy=%b want 1", bus.busy); end
        bus.start = 1'b0;
        wait_done(bc, dc, to);
        vectors++; if (to || dc != 4) begin miscompares++; $display("FAIL b2b_lat2: got done at %0d (timeout=%b) want 4", dc, to); end
        e = sb.pop_front();
        vectors++; if (bus.P !== e.p || bus.match !== e.m) begin
            miscompares++; $display("FAIL b2b_p2: got P=%0d m=%b want P=%0d m=%b", bus.P, bus.match, e.p, e.m);
        end
    endtask

    task automatic test_reset_abort;
        int bc, dc, dones; bit to; exp_t e;
        apply(4'd6, 4'd7, 4'd1, 4'd11, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.P, bus.match, bus.div_err, bus.rem_err} !== 13'd0) begin
            miscompares++;
            $display("FAIL abort_outs: got busy=%b done=%b P=%0d match=%b de=%b re=%b want all 0",
                     bus.busy, bus.done, bus.P, bus.match, bus.div_err, bus.rem_err);
        end
        rst = 1'b0;
        sb.delete();
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        vectors++; if (dones != 0) begin miscompares++; $display("FAIL abort_done: got %0d done pulses want 0", dones); end
        apply(4'd1, 4'd1, 4'd0, 4'd1, 1'b0);
        wait_done(bc, dc, to);
        vectors++; if (to) begin miscompares++; $display("FAIL fresh_timeout: no done within 20 cycles"); end
        e = sb.pop_front();
        vectors++; if (bus.P !== e.p || bus.match !== e.m) begin
            miscompares++; $display("FAIL fresh_p: got P=%0d m=%b want P=%0d m=%b", bus.P, bus.match, e.p, e.m);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.Q = '0; bus.B = '0; bus.R = '0; bus.A_ref = '0;
        rst = 1'b1;
        test_reset();
        test_normal();
        test_max();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
